// File: rtl/world_store.sv
`timescale 1ns/1ps
// world_store: cube-world table with a fixed 3-cycle pipelined read port,
// a single-cycle write port, a self-clearing sweep after reset and a
// running count of valid (live) cube entries.
module world_store #(
  parameter  int unsigned COORD_WIDTH  = 32,
  parameter  int unsigned WORLD_BITS   = 7,
  parameter  int unsigned WORLD_SIZE   = 128,
  parameter  int unsigned READ_LATENCY = 3,
  localparam int unsigned EW           = 3 * COORD_WIDTH / 2 + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [WORLD_BITS-1:0] world_read_addr,
  input  logic                  rd_en_in,
  output logic [EW-1:0]         world_read,
  output logic                  rd_valid_out,
  input  logic [WORLD_BITS-1:0] world_write_addr,
  input  logic [EW-1:0]         world_write,
  input  logic                  wr_en_in,
  output logic                  ready_out,
  output logic [WORLD_BITS:0]   cube_count_out,
  output logic                  busy_out
);

  localparam logic [WORLD_BITS:0]   SIZE_EXT = (WORLD_BITS + 1)'(WORLD_SIZE);
  localparam logic [WORLD_BITS-1:0] LAST_PTR = WORLD_BITS'(WORLD_SIZE - 1);
  localparam logic [WORLD_BITS-1:0] PTR_ONE  = WORLD_BITS'(1);
  localparam logic [WORLD_BITS:0]   CNT_ONE  = (WORLD_BITS + 1)'(1);

  if (READ_LATENCY != 3) begin : g_bad_latency
    $error("world_store: only READ_LATENCY = 3 is supported");
  end
  if (WORLD_SIZE > (1 << WORLD_BITS)) begin : g_bad_size
    $error("world_store: WORLD_SIZE exceeds the address space");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [WORLD_BITS-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [WORLD_SIZE-1:0] shadow_q, shadow_d;
  logic [WORLD_BITS:0]   count_q, count_d;

  logic                  s1_vld_q, s1_vld_d;
  logic [WORLD_BITS-1:0] s1_addr_q, s1_addr_d;
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_oor_q, s2_oor_d;
  logic                  out_vld_q, out_vld_d;
  logic [EW-1:0]         out_data_q, out_data_d;

  logic [EW-1:0]         mem [WORLD_SIZE];
  logic [EW-1:0]         ram_q;
  logic                  mem_we;
  logic [WORLD_BITS-1:0] mem_wa;
  logic [EW-1:0]         mem_wd;

  logic                  run;
  logic                  wr_in_range;
  logic                  wr_fire;
  logic                  old_vld;
  logic                  new_vld;

  // Sweep/run control, shared RAM write port and cube-count bookkeeping
  always_comb begin
    run         = (state_q == ST_RUN);
    wr_in_range = ({1'b0, world_write_addr} < SIZE_EXT);
    wr_fire     = run && wr_en_in && wr_in_range;
    old_vld     = shadow_q[world_write_addr];
    new_vld     = world_write[EW-1];

    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    mem_wa   = world_write_addr;
    mem_wd   = world_write;

    case (state_q)
      ST_CLEAR: begin
        mem_we           = 1'b1;
        mem_wa           = ptr_q;
        mem_wd           = '0;
        shadow_d[ptr_q]  = 1'b0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      ST_RUN: begin
        if (wr_fire) begin
          mem_we                     = 1'b1;
          shadow_d[world_write_addr] = new_vld;
          if (!old_vld && new_vld) begin
            count_d = count_q + CNT_ONE;
          end else if (old_vld && !new_vld) begin
            count_d = count_q - CNT_ONE;
          end
        end
      end
    endcase
  end

  // Read pipeline: address stage, RAM stage, output stage
  always_comb begin
    s1_vld_d   = run && rd_en_in;
    s1_addr_d  = world_read_addr;
    s2_vld_d   = s1_vld_q;
    s2_oor_d   = !({1'b0, s1_addr_q} < SIZE_EXT);
    out_vld_d  = s2_vld_q;
    out_data_d = out_data_q;
    if (s2_vld_q) begin
      out_data_d = s2_oor_q ? '0 : ram_q;
    end
  end

  // Control and pipeline registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      shadow_q   <= '0;
      count_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_oor_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s2_vld_q   <= s2_vld_d;
      s2_oor_q   <= s2_oor_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Simple dual-port RAM; the read sees pre-write contents at the same edge,
  // so writes after the request edge never leak into an in-flight read
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    ram_q <= mem[s1_addr_q];
  end

  assign world_read     = out_data_q;
  assign rd_valid_out   = out_vld_q;
  assign ready_out      = ready_q;
  assign busy_out       = busy_q;
  assign cube_count_out = count_q;

endmodule

// File: tb/tb_world_store.sv
`timescale 1ns/1ps
// Directed bench for world_store: a default 128-entry instance and a
// 100-entry instance for out-of-range address behaviour.
module tb_world_store;

  localparam int EW = 49;
  localparam int WB = 7;

  localparam logic [EW-1:0] V10 = {1'b1, 48'h0001_0002_0003};
  localparam logic [EW-1:0] XV  = {1'b1, 48'hAAAA_BBBB_CCCC};
  localparam logic [EW-1:0] YV  = {1'b1, 48'h1234_5678_9ABC};
  localparam logic [EW-1:0] ZV  = {1'b1, 48'h0F0F_0F0F_0F0F};
  localparam logic [EW-1:0] SV  = {1'b1, 48'h0000_0000_0032};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [WB-1:0] rd_addr_b, wr_addr_b, rd_addr_s, wr_addr_s;
  logic          rd_en_b, wr_en_b, rd_en_s, wr_en_s;
  logic [EW-1:0] wr_data_b, wr_data_s, rdata_b, rdata_s;
  logic          rvld_b, rvld_s, ready_b, ready_s, busy_b, busy_s;
  logic [WB:0]   count_b, count_s;

  int checks = 0;
  int errors = 0;

  world_store u_dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .world_read_addr(rd_addr_b), .rd_en_in(rd_en_b),
    .world_read(rdata_b), .rd_valid_out(rvld_b),
    .world_write_addr(wr_addr_b), .world_write(wr_data_b), .wr_en_in(wr_en_b),
    .ready_out(ready_b), .cube_count_out(count_b), .busy_out(busy_b)
  );

  world_store #(.WORLD_SIZE(100)) u_small (
    .clk_in(clk), .rst_n_in(rst_n),
    .world_read_addr(rd_addr_s), .rd_en_in(rd_en_s),
    .world_read(rdata_s), .rd_valid_out(rvld_s),
    .world_write_addr(wr_addr_s), .world_write(wr_data_s), .wr_en_in(wr_en_s),
    .ready_out(ready_s), .cube_count_out(count_s), .busy_out(busy_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input bit sel, input bit en, input logic [WB-1:0] a);
    if (sel) begin rd_en_s = en; rd_addr_s = a; end
    else     begin rd_en_b = en; rd_addr_b = a; end
  endtask

  task automatic set_wr(input bit sel, input bit en, input logic [WB-1:0] a,
                        input logic [EW-1:0] d);
    if (sel) begin wr_en_s = en; wr_addr_s = a; wr_data_s = d; end
    else     begin wr_en_b = en; wr_addr_b = a; wr_data_b = d; end
  endtask

  task automatic do_write(input bit sel, input logic [WB-1:0] a, input logic [EW-1:0] d);
    set_wr(sel, 1'b1, a, d);
    step();
    set_wr(sel, 1'b0, '0, '0);
  endtask

  // One read request; reports any early valid and the beat 3 cycles later
  task automatic read_once(input bit sel, input logic [WB-1:0] a,
                           output logic [EW-1:0] data, output logic early,
                           output logic late);
    set_rd(sel, 1'b1, a);
    step();
    set_rd(sel, 1'b0, '0);
    early = sel ? rvld_s : rvld_b;
    step();
    early = early | (sel ? rvld_s : rvld_b);
    step();
    late = sel ? rvld_s : rvld_b;
    data = sel ? rdata_s : rdata_b;
  endtask

  // Sweep after reset release, with requests hammered during CLEAR
  task automatic test_clear_sweep(input string tag);
    int nb, ns;
    bit any_vld;
    nb = 0; ns = 0; any_vld = 0;
    set_rd(0, 1'b1, 7'd3); set_wr(0, 1'b1, 7'd3, XV);
    set_rd(1, 1'b1, 7'd3); set_wr(1, 1'b1, 7'd3, XV);
    for (int n = 1; n <= 300 && (nb == 0 || ns == 0); n++) begin
      step();
      if (rvld_b || rvld_s) any_vld = 1;
      if (nb == 0 && !busy_b) begin
        nb = n; set_rd(0, 1'b0, '0); set_wr(0, 1'b0, '0, '0);
      end
      if (ns == 0 && !busy_s) begin
        ns = n; set_rd(1, 1'b0, '0); set_wr(1, 1'b0, '0, '0);
      end
    end
    set_rd(0, 1'b0, '0); set_wr(0, 1'b0, '0, '0);
    set_rd(1, 1'b0, '0); set_wr(1, 1'b0, '0, '0);
    for (int n = 0; n < 4; n++) begin
      step();
      if (rvld_b || rvld_s) any_vld = 1;
    end
    checks++; if (nb !== 128) begin errors++; $display("FAIL %s sweep_len: got %0d expected 128", tag, nb); end
    checks++; if (ns !== 100) begin errors++; $display("FAIL %s sweep_len_small: got %0d expected 100", tag, ns); end
    checks++; if (any_vld !== 1'b0) begin errors++; $display("FAIL %s clear_no_read: got rd_valid %0d expected 0", tag, any_vld); end
    checks++; if ({ready_b, ready_s} !== 2'b11) begin errors++; $display("FAIL %s ready: got %b expected 11", tag, {ready_b, ready_s}); end
    checks++; if (count_b !== 8'd0 || count_s !== 8'd0) begin errors++; $display("FAIL %s clear_count: got %0d/%0d expected 0/0", tag, count_b, count_s); end
  endtask

  task automatic test_reset();
    set_rd(0, 1'b0, '0); set_wr(0, 1'b0, '0, '0);
    set_rd(1, 1'b0, '0); set_wr(1, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    step(); step();
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_b); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_b); end
    checks++; if (count_b !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_b); end
    checks++; if (rvld_b !== 1'b0 || rdata_b !== '0) begin errors++; $display("FAIL reset_read: got vld %b data %h expected 0/0", rvld_b, rdata_b); end
    rst_n = 1'b1;
    test_clear_sweep("initial");
  endtask

  task automatic test_read_idle();
    logic [EW-1:0] d; logic e, l;
    read_once(0, 7'd5, d, e, l);
    checks++; if (e !== 1'b0 || l !== 1'b1) begin errors++; $display("FAIL read5_latency: got early %b late %b expected 0 1", e, l); end
    checks++; if (d !== '0) begin errors++; $display("FAIL read5_data: got %h expected 0", d); end
    read_once(0, 7'd3, d, e, l);
    checks++; if (l !== 1'b1 || d !== '0) begin errors++; $display("FAIL read3_after_clear_write: got vld %b data %h expected 1 0", l, d); end
  endtask

  task automatic test_write_read();
    logic [EW-1:0] d, exp; logic e, l;
    int beats, first, last, bad;
    do_write(0, 7'd10, V10);
    checks++; if (count_b !== 8'd1) begin errors++; $display("FAIL count_write10: got %0d expected 1", count_b); end
    read_once(0, 7'd10, d, e, l);
    checks++; if (l !== 1'b1 || d !== 49'h1_0001_0002_0003) begin errors++; $display("FAIL read10: got vld %b data %h expected 1 1000100020003", l, d); end
    beats = 0; first = -1; last = -1; bad = 0;
    for (int k = 0; k < 134; k++) begin
      if (k < 128) set_rd(0, 1'b1, 7'(k)); else set_rd(0, 1'b0, '0);
      step();
      if (rvld_b) begin
        exp = (beats == 10) ? V10 : '0;
        if (rdata_b !== exp) bad++;
        if (first < 0) first = k;
        last = k;
        beats++;
      end
    end
    checks++; if (beats !== 128 || first !== 2 || last !== 129) begin errors++; $display("FAIL b2b_beats: got %0d beats first %0d last %0d expected 128 2 129", beats, first, last); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_count();
    logic [EW-1:0] d; logic e, l;
    do_write(0, 7'd10, {1'b1, 48'h5});
    checks++; if (count_b !== 8'd1) begin errors++; $display("FAIL count_v2v: got %0d expected 1", count_b); end
    do_write(0, 7'd10, {1'b0, 48'h5});
    checks++; if (count_b !== 8'd0) begin errors++; $display("FAIL count_v2i: got %0d expected 0", count_b); end
    do_write(0, 7'd11, {1'b0, 48'h7});
    checks++; if (count_b !== 8'd0) begin errors++; $display("FAIL count_i2i: got %0d expected 0", count_b); end
    for (int i = 0; i < 128; i++) do_write(0, 7'(i), {1'b1, 48'(i)});
    checks++; if (count_b !== 8'd128) begin errors++; $display("FAIL count_full: got %0d expected 128", count_b); end
    do_write(0, 7'd127, '0);
    checks++; if (count_b !== 8'd127) begin errors++; $display("FAIL count_full_dec: got %0d expected 127", count_b); end
    do_write(0, 7'd127, {1'b1, 48'd127});
    checks++; if (count_b !== 8'd128) begin errors++; $display("FAIL count_full_inc: got %0d expected 128", count_b); end
    read_once(0, 7'd77, d, e, l);
    checks++; if (l !== 1'b1 || d !== {1'b1, 48'd77}) begin errors++; $display("FAIL read77: got vld %b data %h expected 1 %h", l, d, {1'b1, 48'd77}); end
  endtask

  task automatic test_collision();
    logic [EW-1:0] d; logic e, l;
    set_rd(0, 1'b1, 7'd20); set_wr(0, 1'b1, 7'd20, XV);
    step();
    set_rd(0, 1'b0, '0); set_wr(0, 1'b0, '0, '0);
    step(); step();
    checks++; if (rvld_b !== 1'b1 || rdata_b !== XV) begin errors++; $display("FAIL coll_same_edge: got vld %b data %h expected 1 %h", rvld_b, rdata_b, XV); end
    set_rd(0, 1'b1, 7'd20);
    step();
    set_rd(0, 1'b0, '0); set_wr(0, 1'b1, 7'd20, YV);
    step();
    set_wr(0, 1'b0, '0, '0);
    step();
    checks++; if (rvld_b !== 1'b1 || rdata_b !== XV) begin errors++; $display("FAIL coll_t1: got vld %b data %h expected 1 %h", rvld_b, rdata_b, XV); end
    read_once(0, 7'd20, d, e, l);
    checks++; if (l !== 1'b1 || d !== YV) begin errors++; $display("FAIL coll_next_read: got vld %b data %h expected 1 %h", l, d, YV); end
    set_rd(0, 1'b1, 7'd20);
    step();
    set_rd(0, 1'b0, '0);
    step();
    set_wr(0, 1'b1, 7'd20, ZV);
    step();
    set_wr(0, 1'b0, '0, '0);
    checks++; if (rvld_b !== 1'b1 || rdata_b !== YV) begin errors++; $display("FAIL coll_t2: got vld %b data %h expected 1 %h", rvld_b, rdata_b, YV); end
    read_once(0, 7'd20, d, e, l);
    checks++; if (l !== 1'b1 || d !== ZV) begin errors++; $display("FAIL coll_t2_next: got vld %b data %h expected 1 %h", l, d, ZV); end
    checks++; if (count_b !== 8'd128) begin errors++; $display("FAIL coll_count: got %0d expected 128", count_b); end
  endtask

  task automatic test_out_of_range();
    logic [EW-1:0] d; logic e, l;
    do_write(1, 7'd50, SV);
    checks++; if (count_s !== 8'd1) begin errors++; $display("FAIL oor_count_50: got %0d expected 1", count_s); end
    do_write(1, 7'd120, XV);
    checks++; if (count_s !== 8'd1) begin errors++; $display("FAIL oor_count_120: got %0d expected 1", count_s); end
    do_write(1, 7'd99, YV);
    checks++; if (count_s !== 8'd2) begin errors++; $display("FAIL oor_count_99: got %0d expected 2", count_s); end
    read_once(1, 7'd120, d, e, l);
    checks++; if (e !== 1'b0 || l !== 1'b1 || d !== '0) begin errors++; $display("FAIL oor_read120: got early %b vld %b data %h expected 0 1 0", e, l, d); end
    read_once(1, 7'd99, d, e, l);
    checks++; if (l !== 1'b1 || d !== YV) begin errors++; $display("FAIL oor_read99: got vld %b data %h expected 1 %h", l, d, YV); end
    read_once(1, 7'd50, d, e, l);
    checks++; if (l !== 1'b1 || d !== SV) begin errors++; $display("FAIL oor_read50: got vld %b data %h expected 1 %h", l, d, SV); end
  endtask

  task automatic test_reset_midflight();
    logic [EW-1:0] d; logic e, l;
    bit seen;
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    test_clear_sweep("resweep");
    for (int i = 1; i <= 5; i++) do_write(0, 7'(i), {1'b1, 48'(i)});
    checks++; if (count_b !== 8'd5) begin errors++; $display("FAIL mid_count5: got %0d expected 5", count_b); end
    set_rd(0, 1'b1, 7'd1);
    step();
    set_rd(0, 1'b1, 7'd2);
    step();
    set_rd(0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count_b !== 8'd0 || busy_b !== 1'b1 || ready_b !== 1'b0) begin errors++; $display("FAIL mid_async: got count %0d busy %b ready %b expected 0 1 0", count_b, busy_b, ready_b); end
    seen = rvld_b;
    for (int n = 0; n < 4; n++) begin
      step();
      if (rvld_b) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_inflight: got rd_valid %b expected 0", seen); end
    rst_n = 1'b1;
    test_clear_sweep("after_midflight");
    read_once(0, 7'd1, d, e, l);
    checks++; if (l !== 1'b1 || d !== '0) begin errors++; $display("FAIL mid_cleared: got vld %b data %h expected 1 0", l, d); end
  endtask

  initial begin
    test_reset();
    test_read_idle();
    test_write_read();
    test_count();
    test_collision();
    test_out_of_range();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
